// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and FSM encoding for the SHA-256 message schedule
package sha256_pkg;

  localparam int WORD_W     = 32;
  localparam int NUM_ROUNDS = 64;
  localparam int MSG_WORDS  = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/sha256_sigma_small.sv
// rtl/sha256_sigma_small.sv - combinational SHA-256 small sigma0/sigma1 functions
module sha256_sigma_small
  import sha256_pkg::*;
(
  input  word_t s0_x_i,
  input  word_t s1_x_i,
  output word_t sigma0_o,
  output word_t sigma1_o
);

  // Rotations are plain rewiring; only the logical shifts discard bits.
  assign sigma0_o = {s0_x_i[6:0],  s0_x_i[31:7]}
                  ^ {s0_x_i[17:0], s0_x_i[31:18]}
                  ^ (s0_x_i >> 3);

  assign sigma1_o = {s1_x_i[16:0], s1_x_i[31:17]}
                  ^ {s1_x_i[18:0], s1_x_i[31:19]}
                  ^ (s1_x_i >> 10);

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - loads 16 message words, then streams W0..W63 through a sliding window
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_idx,
  output logic        busy
);

  import sha256_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  lcnt_q, lcnt_d;
  logic [5:0]  ecnt_q, ecnt_d;
  word_t       win_q [MSG_WORDS];
  word_t       win_d [MSG_WORDS];

  word_t       sig0, sig1, w_new, shift_word;
  logic        in_hs, out_hs, shift_en;

  sha256_sigma_small u_sigma (
    .s0_x_i   (win_q[1]),
    .s1_x_i   (win_q[14]),
    .sigma0_o (sig0),
    .sigma1_o (sig1)
  );

  assign w_new     = sig1 + win_q[9] + sig0 + win_q[0];

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_EMIT);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_data  = out_valid ? win_q[0] : '0;
  assign out_idx   = ecnt_q;
  assign busy      = (state_q != ST_LOAD) || (lcnt_q != 4'd0);

  always_comb begin
    state_d    = state_q;
    lcnt_d     = lcnt_q;
    ecnt_d     = ecnt_q;
    shift_en   = 1'b0;
    shift_word = in_data;
    if (clr) begin
      state_d = ST_LOAD;
      lcnt_d  = 4'd0;
      ecnt_d  = 6'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_hs) begin
            shift_en = 1'b1;
            lcnt_d   = lcnt_q + 4'd1;
            if (lcnt_q == 4'(MSG_WORDS - 1)) begin
              state_d = ST_EMIT;
              lcnt_d  = 4'd0;
              ecnt_d  = 6'd0;
            end
          end
        end
        ST_EMIT: begin
          if (out_hs) begin
            shift_en   = 1'b1;
            shift_word = w_new;
            ecnt_d     = ecnt_q + 6'd1;
            // The window already holds W63 at ecnt 63, so no W64 is computed into output.
            if (ecnt_q == 6'(NUM_ROUNDS - 1)) begin
              state_d = ST_LOAD;
              ecnt_d  = 6'd0;
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < MSG_WORDS; i++) begin
      win_d[i] = win_q[i];
    end
    if (shift_en) begin
      for (int i = 0; i < MSG_WORDS - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[MSG_WORDS-1] = shift_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      lcnt_q  <= 4'd0;
      ecnt_q  <= 6'd0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      ecnt_q  <= ecnt_d;
      for (int i = 0; i < MSG_WORDS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule
